// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (logic, add/sub, shifts, SLTU), illegal opcodes and
// divide-by-zero finish in one cycle. MUL/MULHU/DIVU/REMU iterate one bit
// per cycle over a shared {hi,lo} working register.
module iter_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_control_op_i,
  input  logic [WIDTH-1:0] a_num_i,
  input  logic [WIDTH-1:0] b_num_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] c_num_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  // sel_q[1]: divide (else multiply); sel_q[0]: result from hi half (else lo)
  logic [1:0]       sel_q;
  // Multiply: addend (a). Divide: divisor (b).
  logic [WIDTH-1:0] opnd_q;
  // Multiply: {hi,lo} is the product register, lo starts as b.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] c_q;
  logic             zero_q;
  logic             illegal_q;

  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic             single_iter;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] iter_res;

  assign shamt       = b_num_i[CW-1:0];
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign c_num_o     = c_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;

  // Decode the request: one-cycle result, or flag that it needs iteration
  always_comb begin
    single_res  = '0;
    single_ill  = 1'b0;
    single_iter = 1'b0;
    case (alu_control_op_i)
      OP_AND:  single_res = a_num_i & b_num_i;
      OP_OR:   single_res = a_num_i | b_num_i;
      OP_ADD:  single_res = a_num_i + b_num_i;
      OP_SUB:  single_res = a_num_i - b_num_i;
      OP_XOR:  single_res = a_num_i ^ b_num_i;
      OP_SLL:  single_res = a_num_i << shamt;
      OP_SRL:  single_res = a_num_i >> shamt;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a_num_i < b_num_i)};
      OP_MUL, OP_MULHU: single_iter = 1'b1;
      OP_DIVU: begin
        if (b_num_i == '0) single_res  = '1;
        else               single_iter = 1'b1;
      end
      OP_REMU: begin
        if (b_num_i == '0) single_res  = a_num_i;
        else               single_iter = 1'b1;
      end
      default: single_ill = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_addend = lo_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    div_shift  = {hi_q, lo_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opnd_q};
    // A set top bit in the shifted remainder already exceeds any divisor;
    // otherwise bit WIDTH of the difference is the borrow.
    div_ge     = div_shift[WIDTH] | ~div_diff[WIDTH];
    if (sel_q[1]) begin
      hi_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    iter_res = sel_q[0] ? hi_nxt : lo_nxt;
  end

  // Control FSM, iteration datapath and registered result
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      c_q       <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            if (single_iter) begin
              state_q <= S_BUSY;
              cnt_q   <= '0;
              sel_q   <= alu_control_op_i[1:0];
              hi_q    <= '0;
              if (alu_control_op_i[1]) begin
                lo_q   <= a_num_i;
                opnd_q <= b_num_i;
              end else begin
                lo_q   <= b_num_i;
                opnd_q <= a_num_i;
              end
            end else begin
              state_q   <= S_DONE;
              c_q       <= single_res;
              zero_q    <= (single_res == '0);
              illegal_q <= single_ill;
            end
          end
        end
        S_BUSY: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          if (cnt_q == CNT_LAST) begin
            state_q   <= S_DONE;
            cnt_q     <= '0;
            c_q       <= iter_res;
            zero_q    <= (iter_res == '0);
            illegal_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_iter_alu;

  localparam int unsigned W = 32;

  localparam logic [3:0] T_AND = 4'b0000, T_OR = 4'b0001, T_ADD = 4'b0010, T_XOR = 4'b0011;
  localparam logic [3:0] T_SLL = 4'b0100, T_SRL = 4'b0101, T_SUB = 4'b0110, T_SLTU = 4'b0111;
  localparam logic [3:0] T_MUL = 4'b1000, T_MULHU = 4'b1001, T_DIVU = 4'b1010, T_REMU = 4'b1011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic         zero;
  logic         illegal;

  int n_cmp = 0;
  int n_bad = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .alu_control_op_i(op),
    .a_num_i         (a),
    .b_num_i         (b),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .c_num_o         (c),
    .zero_o          (zero),
    .illegal_o       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        z;
    logic        ill;
    int unsigned lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xc, input logic xz, input logic xi, input int unsigned xl);
    vec_t v;
    v.op = o; v.a = xa; v.b = xb; v.c = xc; v.z = xz; v.ill = xi; v.lat = xl;
    vecs.push_back(v);
  endtask

  // Reference: plain unsigned arithmetic on 64-bit intermediates
  function automatic void ref_model(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                    output logic [31:0] rc, output logic ri, output int unsigned rl);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = {32'h0, xa} * {32'h0, xb};
    sh = xb[4:0];
    ri = 1'b0;
    rl = 1;
    rc = '0;
    case (o)
      T_AND:   rc = xa & xb;
      T_OR:    rc = xa | xb;
      T_ADD:   rc = xa + xb;
      T_SUB:   rc = xa - xb;
      T_XOR:   rc = xa ^ xb;
      T_SLL:   rc = xa << sh;
      T_SRL:   rc = xa >> sh;
      T_SLTU:  rc = (xa < xb) ? 32'd1 : 32'd0;
      T_MUL:   begin rc = p[31:0];  rl = W + 1; end
      T_MULHU: begin rc = p[63:32]; rl = W + 1; end
      T_DIVU:  begin
        if (xb == 0) rc = 32'hFFFF_FFFF;
        else begin rc = xa / xb; rl = W + 1; end
      end
      T_REMU:  begin
        if (xb == 0) rc = xa;
        else begin rc = xa % xb; rl = W + 1; end
      end
      default: ri = 1'b1;
    endcase
  endfunction

  // Issue one op, wait for its result, then consume it. Starts and ends #1 after an edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input bit hold_ready,
                        output logic [31:0] rc, output logic rz, output logic ri,
                        output int unsigned lat, output bit done, output bit released);
    int unsigned w;
    w = 0; done = 1'b0; released = 1'b0; rc = '0; rz = 1'b0; ri = 1'b0; lat = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) return;
    op = o; a = xa; b = xb; in_valid = 1'b1; out_ready = hold_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin out_ready = 1'b0; return; end
    done = 1'b1; rc = c; rz = zero; ri = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    released = !out_valid && in_ready;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rc, ec, mul_exp;
    logic        rz, ri, eill;
    int unsigned lat, elat, cyc, sel, seen;
    bit          done, released, rdy;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.c", 64'(c), 64'd0);
    check("reset.zero", 64'(zero), 64'd1);
    check("reset.illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of a DIVU: op abandoned, no result afterwards
    op = T_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.c", 64'(c), 64'd0);
    check("midrst.zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("midrst.no_stale", 64'(seen), 64'd0);

    // Directed vectors
    add_vec(T_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
    add_vec(T_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    add_vec(T_SLTU,  32'd3,         32'd5,         32'd1,         1'b0, 1'b0, 1);
    add_vec(T_SLL,   32'd1,         32'h0000_0021, 32'd2,         1'b0, 1'b0, 1);
    add_vec(T_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33);
    add_vec(T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    add_vec(T_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33);
    add_vec(T_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33);
    add_vec(T_DIVU,  32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add_vec(T_REMU,  32'h0000_1234, 32'd0,         32'h0000_1234, 1'b0, 1'b0, 1);
    add_vec(4'b1111, 32'd5,         32'd3,         32'd0,         1'b1, 1'b1, 1);
    add_vec(4'b1100, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b1, 1);
    add_vec(T_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1);
    add_vec(T_OR,    32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1);
    add_vec(T_XOR,   32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1);
    add_vec(T_SRL,   32'h8000_0000, 32'h0000_001F, 32'd1,         1'b0, 1'b0, 1);
    add_vec(T_SLTU,  32'd5,         32'd3,         32'd0,         1'b1, 1'b0, 1);
    add_vec(T_SLTU,  32'd0,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1);
    add_vec(T_DIVU,  32'd7,         32'd100,       32'd0,         1'b1, 1'b0, 33);
    add_vec(T_REMU,  32'd7,         32'd100,       32'd7,         1'b0, 1'b0, 33);
    add_vec(T_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0,         1'b1, 1'b0, 33);
    add_vec(T_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0, 1'b0, 33);
    add_vec(T_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    add_vec(T_SUB,   32'd0,         32'd0,         32'd0,         1'b1, 1'b0, 1);

    foreach (vecs[i]) begin
      // odd entries keep out_ready high throughout: consumed at the first DONE edge
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i % 2) == 1, rc, rz, ri, lat, done, released);
      check($sformatf("v%0d.done", i), 64'(done), 64'd1);
      if (done) begin
        check($sformatf("v%0d.c", i), 64'(rc), 64'(vecs[i].c));
        check($sformatf("v%0d.zero", i), 64'(rz), 64'(vecs[i].z));
        check($sformatf("v%0d.illegal", i), 64'(ri), 64'(vecs[i].ill));
        check($sformatf("v%0d.latency", i), 64'(lat), 64'(vecs[i].lat));
        check($sformatf("v%0d.consumed", i), 64'(released), 64'd1);
      end
    end

    // Backpressure after a MUL: result held, new requests ignored
    ref_model(T_MUL, 32'h1234_5678, 32'h9ABC_DEF0, mul_exp, eill, elat);
    op = T_MUL; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("bp.latency", 64'(lat), 64'd33);
    check("bp.c", 64'(c), 64'(mul_exp));
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; op = T_ADD; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.c", k), 64'(c), 64'(mul_exp));
      check($sformatf("bp.hold%0d.out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp.hold%0d.in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp.consume.out_valid", 64'(out_valid), 64'd0);
    check("bp.consume.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp.after.out_valid", 64'(out_valid), 64'd0);
    check("bp.after.in_ready", 64'(in_ready), 64'd1);

    // Random ops under random valid/ready
    for (int i = 0; i < 1000; i++) begin
      ro  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 2) ra = 32'($urandom_range(0, 255));
      ref_model(ro, ra, rb, ec, eill, elat);
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      op = ro; a = ra; b = rb; in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!out_valid && lat < 200) begin
        in_valid = 1'($urandom_range(0, 1)); op = 4'($urandom); a = $urandom; b = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("rnd%0d.done", i), 64'(out_valid), 64'd1);
      if (!out_valid) begin
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        continue;
      end
      check($sformatf("rnd%0d.c op=%0h a=%0h b=%0h", i, ro, ra, rb), 64'(c), 64'(ec));
      check($sformatf("rnd%0d.zero", i), 64'(zero), 64'(ec == 0));
      check($sformatf("rnd%0d.illegal", i), 64'(illegal), 64'(eill));
      check($sformatf("rnd%0d.latency", i), 64'(lat), 64'(elat));
      cyc = 0; rdy = 1'b0;
      while (!rdy) begin
        rdy = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready = rdy;
        in_valid  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cyc++;
        if (!rdy) begin
          check($sformatf("rnd%0d.hold.c", i), 64'(c), 64'(ec));
          check($sformatf("rnd%0d.hold.out_valid", i), 64'(out_valid), 64'd1);
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check($sformatf("rnd%0d.consume.out_valid", i), 64'(out_valid), 64'd0);
      check($sformatf("rnd%0d.consume.in_ready", i), 64'(in_ready), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
